// File: rtl/frame_ram_clr.sv
// frame_ram_clr: synchronous dual-port frame RAM with a built-in clear sequencer.
//
// Port A reads and writes (game logic). Port B only reads (pixel scanner).
// When clr_start is seen in IDLE, the sequencer owns the write path and writes
// CLEAR_VALUE to words 0..DEPTH-1, one word per cycle. It then pulses clr_done.
// Only DEPTH words are implemented. Addresses >= DEPTH read as CLEAR_VALUE,
// and writes to them are dropped.
//
// Optional build macro: FRAME_RAM_OUT_REG_EN
//   Adds an output register on dout_a/dout_b, so read latency becomes 2 cycles.
//   The output registers reset to CLEAR_VALUE.
//
// Ports:
//   clk, reset        single rising-edge clock, synchronous active-high reset
//   clr_start         clear request, sampled in IDLE only
//   clr_busy          high while the sequencer owns the write path
//   clr_done          one-cycle pulse when a clear completes
//   we_a/addr_a/din_a port A write
//   dout_a            port A read data
//   addr_b/dout_b     port B read address and read data
//   wr_drop           registered flag: the previous port A write was discarded
//
// Handshake: there is no valid/ready pair. clr_start is a level that is
// sampled only in IDLE. clr_busy high means port A writes are refused, and
// each refused write is flagged on wr_drop one cycle later.
module frame_ram_clr #(
  parameter int ADDR_WIDTH = 19,
  parameter int DATA_WIDTH = 3,
  parameter int DEPTH      = 307200,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  wr_drop
);

  // Index width into the implemented array. It never exceeds ADDR_WIDTH
  // because DEPTH <= 2**ADDR_WIDTH.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Range checks are done one bit wider, so that DEPTH = 2**ADDR_WIDTH is
  // still representable.
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
  // The clear ends on a match with the last index, not on ptr reaching
  // DEPTH, so the pointer never has to hold a value that would overflow.
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR  = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

  logic                  a_in_range;
  logic                  a_wr_ok;
  logic                  clr_wr;
  logic [DATA_WIDTH-1:0] rd_a;
  logic [DATA_WIDTH-1:0] rd_b;

  assign a_in_range = ({1'b0, addr_a} < DEPTH_EXT);
  assign a_wr_ok    = we_a && (state == S_IDLE) && a_in_range;
  // A reset edge during a clear must not write another word.
  assign clr_wr     = (state == S_CLEAR) && !reset;
  assign clr_busy   = (state == S_CLEAR);

  // Sequencer FSM, address registers and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      clr_done <= 1'b0;
      wr_drop  <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
    end else begin
      clr_done <= 1'b0;
      wr_drop  <= we_a && !a_wr_ok;
      addr_a_q <= addr_a;
      addr_b_q <= addr_b;
      case (state)
        S_IDLE: begin
          if (clr_start) begin
            state <= S_CLEAR;
            ptr   <= '0;
          end
        end
        S_CLEAR: begin
          if (ptr == LAST_PTR) begin
            state    <= S_IDLE;
            clr_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Single write port, shared between the sequencer and port A. The two never
  // write in the same cycle, because port A is refused outside IDLE.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      ram[ptr[IDX_W-1:0]] <= CLEAR_VALUE;
    end else if (a_wr_ok) begin
      ram[addr_a[IDX_W-1:0]] <= din_a;
    end
  end

  // Reads use the registered address against the current array contents. A
  // write at an edge is therefore visible in the first cycle after it.
  assign rd_a = ({1'b0, addr_a_q} < DEPTH_EXT) ? ram[addr_a_q[IDX_W-1:0]] : CLEAR_VALUE;
  assign rd_b = ({1'b0, addr_b_q} < DEPTH_EXT) ? ram[addr_b_q[IDX_W-1:0]] : CLEAR_VALUE;

`ifdef FRAME_RAM_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_a <= CLEAR_VALUE;
      dout_b <= CLEAR_VALUE;
    end else begin
      dout_a <= rd_a;
      dout_b <= rd_b;
    end
  end
`else
  assign dout_a = rd_a;
  assign dout_b = rd_b;
`endif

endmodule

// File: tb/tb_frame_ram_clr.sv
// Bench for frame_ram_clr. It drives one DEPTH=12 instance and one DEPTH=16
// instance (ADDR_WIDTH=4 for both), and compares them with an array model of
// the frame contents.
module tb_frame_ram_clr;

`ifdef FRAME_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam logic [2:0] CV = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       clr_start = 1'b0;
  logic       we_a = 1'b0;
  logic [3:0] addr_a = '0;
  logic [2:0] din_a = '0;
  logic [3:0] addr_b = '0;
  logic       sel16 = 1'b0;

  logic       clr_start12, clr_start16;
  logic       busy12, done12, drop12, busy16, done16, drop16;
  logic [2:0] da12, db12, da16, db16;
  logic       clr_busy, clr_done, wr_drop;
  logic [2:0] dout_a, dout_b;

  assign clr_start12 = clr_start & ~sel16;
  assign clr_start16 = clr_start & sel16;
  assign clr_busy = sel16 ? busy16 : busy12;
  assign clr_done = sel16 ? done16 : done12;
  assign wr_drop  = sel16 ? drop16 : drop12;
  assign dout_a   = sel16 ? da16 : da12;
  assign dout_b   = sel16 ? db16 : db12;

  frame_ram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(3), .DEPTH(12), .CLEAR_VALUE(3'b111)) u_dut (
    .clk(clk), .reset(reset), .clr_start(clr_start12), .clr_busy(busy12),
    .clr_done(done12), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(da12), .addr_b(addr_b), .dout_b(db12), .wr_drop(drop12)
  );

  frame_ram_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(3), .DEPTH(16), .CLEAR_VALUE(3'b111)) u_dut16 (
    .clk(clk), .reset(reset), .clr_start(clr_start16), .clr_busy(busy16),
    .clr_done(done16), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(da16), .addr_b(addr_b), .dout_b(db16), .wr_drop(drop16)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [2:0] mem [16];
  int         dep = 12;
  int         n_checks = 0;
  int         n_errors = 0;
  logic [2:0] exp_q[$];

  function automatic logic [2:0] exp_rd(input int a);
    return (a >= dep) ? CV : mem[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [2:0] d);
    we_a = 1'b1; addr_a = 4'(a); din_a = d;
    step();
    we_a = 1'b0;
    check("wr_drop_idle", 32'(wr_drop), 32'(a >= dep));
    if (a < dep) mem[a] = d;
  endtask

  task automatic preload(input logic [2:0] v);
    for (int i = 0; i < dep; i++) wr(i, v);
  endtask

  task automatic rd_check(input int a, input int b);
    logic [2:0] ea, eb;
    we_a = 1'b0; addr_a = 4'(a); addr_b = 4'(b);
    exp_q.push_back(exp_rd(a));
    exp_q.push_back(exp_rd(b));
    repeat (LAT) step();
    ea = exp_q.pop_front();
    eb = exp_q.pop_front();
    check("dout_a", 32'(dout_a), 32'(ea));
    check("dout_b", 32'(dout_b), 32'(eb));
  endtask

  task automatic check_all();
    for (int i = 0; i < 16; i++) rd_check(i, 15 - i);
  endtask

  // Full clear. inject=1 adds a write and a second clr_start while busy.
  task automatic run_clear(input bit inject);
    int cnt;
    // A port A write on the clr_start edge is still honoured.
    clr_start = 1'b1; we_a = 1'b1; addr_a = 4'd0; din_a = 3'b010;
    step();
    clr_start = 1'b0; we_a = 1'b0;
    mem[0] = 3'b010;
    check("busy_rise", 32'(clr_busy), 32'd1);
    check("wr_start_kept", 32'(wr_drop), 32'd0);
    cnt = 0;
    while (clr_busy && cnt < 100) begin
      if (inject && cnt == 2) begin we_a = 1'b1; addr_a = 4'd3; din_a = 3'b010; end
      if (inject && cnt == 5) clr_start = 1'b1;
      step();
      cnt++;
      we_a = 1'b0; clr_start = 1'b0;
      if (inject && cnt == 3) check("wr_drop_clr", 32'(wr_drop), 32'd1);
      if (clr_busy) check("done_low", 32'(clr_done), 32'd0);
    end
    check("busy_len", 32'(cnt), 32'(dep));
    check("done_pulse", 32'(clr_done), 32'd1);
    for (int i = 0; i < dep; i++) mem[i] = CV;
    // A write in the first cycle after busy falls is honoured.
    we_a = 1'b1; addr_a = 4'd7; din_a = 3'b011;
    step();
    we_a = 1'b0;
    mem[7] = 3'b011;
    check("done_once", 32'(clr_done), 32'd0);
    check("wr_fall_kept", 32'(wr_drop), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    step(); step();
    check("rst_busy", 32'(clr_busy), 32'd0);
    check("rst_done", 32'(clr_done), 32'd0);
    check("rst_drop", 32'(wr_drop), 32'd0);
`ifdef FRAME_RAM_OUT_REG_EN
    check("rst_dout_a", 32'(dout_a), 32'(CV));
    check("rst_dout_b", 32'(dout_b), 32'(CV));
`endif
    reset = 1'b0;

    // Basic write: the data is visible to both ports right after the write edge.
    we_a = 1'b1; addr_a = 4'd5; din_a = 3'b010; addr_b = 4'd5;
    step();
    we_a = 1'b0;
    if (LAT == 2) step();
    check("wfirst_b", 32'(dout_b), 32'd2);
    check("wfirst_a", 32'(dout_a), 32'd2);
    mem[5] = 3'b010;

    // Full clear of a 001-filled frame.
    preload(3'b001);
    run_clear(1'b0);
    check_all();

    // Clear with a dropped write and an ignored second clr_start.
    preload(3'b001);
    run_clear(1'b1);
    check_all();

    // Out-of-range write and read.
    wr(14, 3'b000);
    check_all();

    // Randomized writes and reads against the model.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 15), 3'($urandom_range(0, 7)));
      rd_check($urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Reset after 5 clear cycles.
    preload(3'b001);
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (5) begin
      step();
      check("mid_done_low", 32'(clr_done), 32'd0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_busy", 32'(clr_busy), 32'd0);
    check("rst_mid_done", 32'(clr_done), 32'd0);
    for (int i = 0; i < 5; i++) mem[i] = CV;
    check_all();

    // DEPTH = 2**ADDR_WIDTH: no pointer wrap, and word 15 is cleared.
    sel16 = 1'b1;
    dep = 16;
    step();
    preload(3'b001);
    wr(15, 3'b000);
    run_clear(1'b0);
    check_all();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
